counter_nbit: RTL and testbench

COUNTER_NBIT -- requirements
Module: counter_nbit

---
 rtl/counter_nbit.sv | 67 ++++++
 tb/tb_counter_nbit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_nbit.sv
// Modulo-N up/down counter with load, optional saturation, terminal-count,
// cascade carry, one-cycle wrap pulse and sticky overrun flag.
module counter_nbit #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = 256,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             co,
  output logic             wrap,
  output logic             ovf
);
  localparam longint unsigned SPAN = 64'd1 << WIDTH;
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 64'd1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("counter_nbit: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || MODULUS > SPAN) begin : g_bad_modulus
    $error("counter_nbit: MODULUS must be 2..2**WIDTH");
  end

  // A full-range modulus needs no load clamp: every d is already legal.
  logic [WIDTH-1:0] d_lim;
  if (MODULUS == SPAN) begin : g_full
    assign d_lim = d;
  end else begin : g_part
    assign d_lim = (d > TOP) ? TOP : d;
  end

  assign tc = up ? (q == TOP) : (q == '0);
  assign co = en & tc & ~ld & ~clr;

  always_ff @(posedge clk) begin
    if (clr) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (ld) begin
      q    <= d_lim;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (en) begin
      if (tc) begin
        ovf <= 1'b1;
        if (SATURATE) begin
          wrap <= 1'b0;
        end else begin
          q    <= up ? '0 : TOP;
          wrap <= 1'b1;
        end
      end else begin
        q    <= up ? q + WIDTH'(1) : q - WIDTH'(1);
        wrap <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end
endmodule

// File: tb/tb_counter_nbit.sv
// Randomized and directed check of several counter_nbit configurations,
// including a two-stage cascade treated as one 8-bit counter.
module tb_counter_nbit;
  // channels: 0 = 4b/10 wrap, 1 = 4b/10 saturate, 2 = 8b/256 wrap,
  //           3 = 4b/16 wrap, 4 = two cascaded 4b/16 stages
  localparam int NCH = 5;
  localparam int MODS [NCH] = '{10, 10, 256, 16, 256};
  localparam bit SATS [NCH] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  typedef struct {
    int q;
    bit wrap;
    bit ovf;
    bit vld;
  } st_t;

  logic clk = 1'b0;
  logic [NCH-1:0] clr = '0, ld = '0, en = '0, up = '0;
  logic [NCH-1:0][7:0] d = '0;

  logic [3:0] q0, q1, q3, ql, qh;
  logic [7:0] q2;
  logic [NCH-1:0] wr, ov, tcv, cov;
  logic wr_lo, ov_lo, tc_lo, co_lo;

  int checks = 0, failures = 0;
  st_t m [NCH];

  always #5 clk = ~clk;

  counter_nbit #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_a (
    .clk(clk), .clr(clr[0]), .en(en[0]), .up(up[0]), .ld(ld[0]), .d(d[0][3:0]),
    .q(q0), .tc(tcv[0]), .co(cov[0]), .wrap(wr[0]), .ovf(ov[0]));
  counter_nbit #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_b (
    .clk(clk), .clr(clr[1]), .en(en[1]), .up(up[1]), .ld(ld[1]), .d(d[1][3:0]),
    .q(q1), .tc(tcv[1]), .co(cov[1]), .wrap(wr[1]), .ovf(ov[1]));
  counter_nbit #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0)) u_c (
    .clk(clk), .clr(clr[2]), .en(en[2]), .up(up[2]), .ld(ld[2]), .d(d[2]),
    .q(q2), .tc(tcv[2]), .co(cov[2]), .wrap(wr[2]), .ovf(ov[2]));
  counter_nbit #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_e (
    .clk(clk), .clr(clr[3]), .en(en[3]), .up(up[3]), .ld(ld[3]), .d(d[3][3:0]),
    .q(q3), .tc(tcv[3]), .co(cov[3]), .wrap(wr[3]), .ovf(ov[3]));
  counter_nbit #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_lo (
    .clk(clk), .clr(clr[4]), .en(en[4]), .up(up[4]), .ld(ld[4]), .d(d[4][3:0]),
    .q(ql), .tc(tc_lo), .co(co_lo), .wrap(wr_lo), .ovf(ov_lo));
  counter_nbit #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_hi (
    .clk(clk), .clr(clr[4]), .en(co_lo), .up(up[4]), .ld(ld[4]), .d(d[4][7:4]),
    .q(qh), .tc(tcv[4]), .co(cov[4]), .wrap(wr[4]), .ovf(ov[4]));

  // Reference: next value is the step taken in integer space, then folded
  // back into 0..mod-1 (wrap) or pinned (saturate) when it leaves the range.
  function automatic st_t step(st_t s, int md, bit sat, bit c, bit l, bit e, bit u, int dv);
    st_t n;
    int raw;
    n = s;
    n.wrap = 1'b0;
    if (c) begin
      n.q = 0; n.ovf = 1'b0; n.vld = 1'b1;
    end else if (l) begin
      n.q = (dv < md) ? dv : md - 1;
      n.ovf = 1'b0;
    end else if (e) begin
      raw = u ? s.q + 1 : s.q - 1;
      if (raw < 0 || raw >= md) begin
        n.ovf = 1'b1;
        if (!sat) begin
          n.q = (raw + md) % md;
          n.wrap = 1'b1;
        end
      end else begin
        n.q = raw;
      end
    end
    return n;
  endfunction

  function automatic int act_q(int i);
    case (i)
      0: return int'(q0);
      1: return int'(q1);
      2: return int'(q2);
      3: return int'(q3);
      default: return int'({qh, ql});
    endcase
  endfunction

  function automatic bit act_tc(int i);
    return (i == 4) ? (tc_lo & tcv[4]) : tcv[i];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int i);
    int md;
    bit etc, eco;
    md  = MODS[i];
    etc = up[i] ? (m[i].q == md - 1) : (m[i].q == 0);
    eco = en[i] & etc & ~ld[i] & ~clr[i];
    chk($sformatf("ch%0d_q", i), act_q(i), m[i].q);
    chk($sformatf("ch%0d_wrap", i), int'(wr[i]), int'(m[i].wrap));
    chk($sformatf("ch%0d_ovf", i), int'(ov[i]), int'(m[i].ovf));
    chk($sformatf("ch%0d_tc", i), int'(act_tc(i)), int'(etc));
    chk($sformatf("ch%0d_co", i), int'(cov[i]), int'(eco));
  endtask

  initial for (int i = 0; i < NCH; i++) m[i] = '{q: 0, wrap: 1'b0, ovf: 1'b0, vld: 1'b0};

  always @(posedge clk)
    for (int i = 0; i < NCH; i++)
      m[i] <= step(m[i], MODS[i], SATS[i], clr[i], ld[i], en[i], up[i], int'(d[i]));

  always @(negedge clk)
    for (int i = 0; i < NCH; i++)
      if (m[i].vld) cmp(i);

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    clr = '1;
    tick();
    clr = '0;
    chk("rst_q0", act_q(0), 0);
    chk("rst_ovf2", int'(ov[2]), 0);

    // modulus-10 wrap: twelve ups end on 2 with overrun latched
    en[0] = 1'b1; up[0] = 1'b1;
    tick(9);
    chk("m10_q9", act_q(0), 9);
    chk("m10_tc9", int'(tcv[0]), 1);
    tick();
    chk("m10_wrap", int'(wr[0]), 1);
    tick(2);
    chk("m10_q2", act_q(0), 2);
    chk("m10_ovf", int'(ov[0]), 1);
    chk("m10_wrap_gone", int'(wr[0]), 0);

    // loads: plain, clamped, and overridden by clear
    ld[0] = 1'b1; d[0] = 8'd7;
    tick();
    chk("ld7_q", act_q(0), 7);
    chk("ld7_ovf", int'(ov[0]), 0);
    d[0] = 8'd13;
    tick();
    chk("ld13_clamp", act_q(0), 9);
    clr[0] = 1'b1; d[0] = 8'd5;
    tick();
    chk("ldclr_q", act_q(0), 0);
    clr[0] = 1'b0; ld[0] = 1'b0; en[0] = 1'b0;

    // saturating: down from 0 holds, then up moves normally
    en[1] = 1'b1; up[1] = 1'b0;
    tick(3);
    chk("sat_q0", act_q(1), 0);
    chk("sat_ovf", int'(ov[1]), 1);
    chk("sat_nowrap", int'(wr[1]), 0);
    up[1] = 1'b1;
    tick(2);
    chk("sat_q2", act_q(1), 2);
    chk("sat_ovf_sticky", int'(ov[1]), 1);
    en[1] = 1'b0;

    // full-range 8-bit wraps both ways
    ld[2] = 1'b1; d[2] = 8'd255;
    tick();
    ld[2] = 1'b0; en[2] = 1'b1; up[2] = 1'b1;
    tick();
    chk("w8_up_q", act_q(2), 0);
    chk("w8_up_wrap", int'(wr[2]), 1);
    up[2] = 1'b0;
    tick();
    chk("w8_dn_q", act_q(2), 255);
    chk("w8_dn_wrap", int'(wr[2]), 1);
    en[2] = 1'b0;

    // mid-count clear
    en[3] = 1'b1; up[3] = 1'b1;
    tick(6);
    chk("mid_q6", act_q(3), 6);
    clr[3] = 1'b1;
    tick();
    chk("mid_clr_q", act_q(3), 0);
    chk("mid_clr_ovf", int'(ov[3]), 0);
    clr[3] = 1'b0;
    tick();
    chk("mid_q1", act_q(3), 1);
    en[3] = 1'b0;

    // cascade acts as a single 8-bit counter
    en[4] = 1'b1; up[4] = 1'b1;
    tick(300);
    chk("casc_300", act_q(4), 44);
    ld[4] = 1'b1; d[4] = 8'd0;
    tick();
    ld[4] = 1'b0; up[4] = 1'b0;
    tick();
    chk("casc_dn", act_q(4), 255);
    chk("casc_wrap", int'(wr[4]), 1);

    // randomized traffic on every channel
    repeat (1500) begin
      for (int i = 0; i < NCH; i++) begin
        clr[i] = ($urandom % 40) == 0;
        ld[i]  = ($urandom % 8) == 0;
        en[i]  = ($urandom % 4) != 0;
        up[i]  = ($urandom % 5) < 3;
        d[i]   = (i == 2 || i == 4) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
